// File: rtl/cache_mem_xfer.sv
// Line transfer engine between the cache controller and word-addressed backing memory.
// Optional critical-word-first fill ordering is enabled by defining CACHE_MEM_XFER_CWF_EN.
module cache_mem_xfer #(
   parameter int LINE_WORDS = 4,
   parameter int OFS_W      = $clog2(LINE_WORDS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_wb,
   input  logic             req_fill,
   input  logic [31:0]      wb_addr,
   input  logic [31:0]      fill_addr,
   output logic [OFS_W-1:0] wr_idx,
   input  logic [31:0]      wr_word,
   output logic             rd_valid,
   output logic [OFS_W-1:0] rd_idx,
   output logic [31:0]      rd_data,
   output logic             done,
   output logic             mem_ren,
   output logic             mem_wen,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_din,
   input  logic [31:0]      mem_dout
);

   typedef enum logic [2:0] {S_IDLE, S_WB, S_FILL, S_DRAIN, S_ACK} state_t;

   state_t              state_q, state_d;
   logic [OFS_W-1:0]    cnt_q, cnt_d;
   logic [31-OFS_W:0]   wb_base_q, wb_base_d;
   logic [31-OFS_W:0]   fill_base_q, fill_base_d;
   logic                fill_q, fill_d;
   logic                pend_q, pend_d;
   logic [OFS_W-1:0]    pend_idx_q, pend_idx_d;
   logic [OFS_W-1:0]    ofs;
   logic                last;

`ifdef CACHE_MEM_XFER_CWF_EN
   logic [OFS_W-1:0]    crit_q, crit_d;
   logic                unused_bits;

   // Offset arithmetic wraps naturally in OFS_W bits, so the base never sees a carry.
   assign ofs         = crit_q + cnt_q;
   assign unused_bits = ^wb_addr[OFS_W-1:0];
`else
   logic                unused_bits;

   assign ofs         = cnt_q;
   assign unused_bits = ^{wb_addr[OFS_W-1:0], fill_addr[OFS_W-1:0]};
`endif

   assign last = &cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         wb_base_q   <= '0;
         fill_base_q <= '0;
         fill_q      <= 1'b0;
         pend_q      <= 1'b0;
         pend_idx_q  <= '0;
`ifdef CACHE_MEM_XFER_CWF_EN
         crit_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wb_base_q   <= wb_base_d;
         fill_base_q <= fill_base_d;
         fill_q      <= fill_d;
         pend_q      <= pend_d;
         pend_idx_q  <= pend_idx_d;
`ifdef CACHE_MEM_XFER_CWF_EN
         crit_q      <= crit_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wb_base_d   = wb_base_q;
      fill_base_d = fill_base_q;
      fill_d      = fill_q;
      pend_d      = 1'b0;
      pend_idx_d  = '0;
`ifdef CACHE_MEM_XFER_CWF_EN
      crit_d      = crit_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               wb_base_d   = wb_addr[31:OFS_W];
               fill_base_d = fill_addr[31:OFS_W];
               fill_d      = req_fill;
               cnt_d       = '0;
`ifdef CACHE_MEM_XFER_CWF_EN
               crit_d      = fill_addr[OFS_W-1:0];
`endif
               if (req_wb)        state_d = S_WB;
               else if (req_fill) state_d = S_FILL;
               else               state_d = S_ACK;
            end
         end
         S_WB: begin
            cnt_d = cnt_q + 1'b1;
            // cnt wraps to 0 here, so the fill starts immediately with no gap.
            if (last) state_d = fill_q ? S_FILL : S_ACK;
         end
         S_FILL: begin
            cnt_d      = cnt_q + 1'b1;
            pend_d     = 1'b1;
            pend_idx_d = ofs;
            if (last) state_d = S_DRAIN;
         end
         S_DRAIN: state_d = S_IDLE;
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state_q == S_IDLE);
      mem_wen   = (state_q == S_WB);
      mem_ren   = (state_q == S_FILL);
      done      = (state_q == S_DRAIN) || (state_q == S_ACK);
      mem_addr  = '0;
      mem_din   = '0;
      wr_idx    = '0;
      if (state_q == S_WB) begin
         mem_addr = {wb_base_q, cnt_q};
         mem_din  = wr_word;
         wr_idx   = cnt_q;
      end else if (state_q == S_FILL) begin
         mem_addr = {fill_base_q, ofs};
      end
   end

   assign rd_valid = pend_q;
   assign rd_idx   = pend_idx_q;
   assign rd_data  = mem_dout;

endmodule

// File: tb/tb_cache_mem_xfer.sv
// Directed bench for cache_mem_xfer with a 1-cycle-latency memory model.
// Build with CACHE_MEM_XFER_CWF_EN defined to check critical-word-first ordering.
module tb_cache_mem_xfer;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_wb, req_fill;
   logic [31:0] wb_addr, fill_addr;
   logic [1:0]  wr_idx, rd_idx;
   logic [31:0] wr_word, rd_data, mem_addr, mem_din;
   logic [31:0] mem_dout;
   logic        rd_valid, done, mem_ren, mem_wen;
   logic        preload;
   logic [31:0] mem [0:1023];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   cache_mem_xfer #(.LINE_WORDS(4), .OFS_W(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_wb(req_wb), .req_fill(req_fill),
      .wb_addr(wb_addr), .fill_addr(fill_addr),
      .wr_idx(wr_idx), .wr_word(wr_word),
      .rd_valid(rd_valid), .rd_idx(rd_idx), .rd_data(rd_data),
      .done(done),
      .mem_ren(mem_ren), .mem_wen(mem_wen),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   assign wr_word = 32'h55 + {30'b0, wr_idx};

   function automatic logic [31:0] init_val(input logic [31:0] a);
      if (a[31:8] == 24'h1) return 32'hA0 + {24'b0, a[7:0]};
      return 32'h1000 + a;
   endfunction

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
      end else begin
         if (mem_wen) mem[mem_addr[9:0]] <= mem_din;
         if (mem_ren) mem_dout <= mem[mem_addr[9:0]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] fofs(input logic [31:0] fa, input int k);
`ifdef CACHE_MEM_XFER_CWF_EN
      return fa[1:0] + 2'(k);
`else
      return 2'(k);
`endif
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // One request; expected per-cycle activity follows the latency rules for each flag mix.
   task automatic xfer(input string tag, input logic wb, input logic fill,
                       input logic [31:0] wba, input logic [31:0] fa);
      int nwb = wb ? 4 : 0;
      int total = nwb + (fill ? 4 : 0) + 1;
      logic [1:0] o;
      req_valid = 1'b1; req_wb = wb; req_fill = fill; wb_addr = wba; fill_addr = fa;
      chk({tag, ".ready_pre"}, req_ready, 1);
      tick();
      req_valid = 1'b0; req_wb = 1'b0; req_fill = 1'b0;
      wb_addr = 32'hDEAD_BEEF; fill_addr = 32'hDEAD_BEEF;
      for (int c = 1; c <= total; c++) begin
         logic ew, er, ev;
         ew = wb && (c <= 4);
         er = fill && (c > nwb) && (c <= nwb + 4);
         ev = fill && (c > nwb + 1);
         chk($sformatf("%s.c%0d.wen", tag, c), mem_wen, ew);
         chk($sformatf("%s.c%0d.ren", tag, c), mem_ren, er);
         chk($sformatf("%s.c%0d.done", tag, c), done, c == total);
         chk($sformatf("%s.c%0d.ready", tag, c), req_ready, 0);
         chk($sformatf("%s.c%0d.rd_valid", tag, c), rd_valid, ev);
         if (ew) begin
            chk($sformatf("%s.c%0d.waddr", tag, c), mem_addr, {wba[31:2], 2'(c - 1)});
            chk($sformatf("%s.c%0d.din", tag, c), mem_din, 32'h55 + 32'(c - 1));
         end
         if (er) begin
            o = fofs(fa, c - nwb - 1);
            chk($sformatf("%s.c%0d.raddr", tag, c), mem_addr, {fa[31:2], o});
         end
         if (ev) begin
            o = fofs(fa, c - nwb - 2);
            chk($sformatf("%s.c%0d.rd_idx", tag, c), rd_idx, o);
            chk($sformatf("%s.c%0d.rd_data", tag, c), rd_data, init_val({fa[31:2], o}));
         end
         tick();
      end
      chk({tag, ".done_after"}, done, 0);
      chk({tag, ".ready_after"}, req_ready, 1);
      chk({tag, ".rd_valid_after"}, rd_valid, 0);
   endtask

   initial begin
      rst = 1'b1; preload = 1'b1;
      req_valid = 1'b0; req_wb = 1'b0; req_fill = 1'b0;
      wb_addr = '0; fill_addr = '0;
      tick();
      chk("rst.ready", req_ready, 1);
      chk("rst.ren", mem_ren, 0);
      chk("rst.wen", mem_wen, 0);
      chk("rst.done", done, 0);
      chk("rst.rd_valid", rd_valid, 0);
      chk("rst.addr", mem_addr, 0);
      chk("rst.din", mem_din, 0);
      chk("rst.rd_idx", rd_idx, 0);
      chk("rst.wr_idx", wr_idx, 0);
      tick();
      rst = 1'b0; preload = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("idle%0d.ready", i), req_ready, 1);
         chk($sformatf("idle%0d.strobes", i), {mem_ren, mem_wen, done, rd_valid}, 0);
      end

      // Fill-only with a non-zero critical offset.
      xfer("fill102", 1'b0, 1'b1, 32'h0, 32'h102);

      // Writeback then fill, back-to-back.
      xfer("wbfill", 1'b1, 1'b1, 32'h200, 32'h100);
      for (int i = 0; i < 4; i++)
         chk($sformatf("readback%0d", i), mem[10'h200 + 10'(i)], 32'h55 + 32'(i));

      // Writeback-only with junk low bits on the victim address.
      xfer("wb3a7", 1'b1, 1'b0, 32'h3A7, 32'h0);
      for (int i = 0; i < 4; i++)
         chk($sformatf("wb3a7.mem%0d", i), mem[10'h3A4 + 10'(i)], 32'h55 + 32'(i));

      // Fill at the top word of a line: offsets must wrap within the line.
      xfer("fill3ff", 1'b0, 1'b1, 32'h0, 32'h3FF);

      // Empty request held high: done in cycle 1, re-accepted in cycle 2.
      req_valid = 1'b1; req_wb = 1'b0; req_fill = 1'b0;
      tick();
      chk("empty.c1.done", done, 1);
      chk("empty.c1.strobes", {mem_ren, mem_wen}, 0);
      chk("empty.c1.ready", req_ready, 0);
      tick();
      chk("empty.c2.done", done, 0);
      chk("empty.c2.ready", req_ready, 1);
      tick();
      chk("empty.c3.done", done, 1);
      req_valid = 1'b0;
      tick();
      chk("empty.c4.done", done, 0);
      chk("empty.c4.ready", req_ready, 1);

      // Reset during the second fill read aborts without a done pulse.
      req_valid = 1'b1; req_fill = 1'b1; fill_addr = 32'h100;
      tick();
      req_valid = 1'b0; req_fill = 1'b0;
      chk("abort.c1.ren", mem_ren, 1);
      tick();
      chk("abort.c2.ren", mem_ren, 1);
      chk("abort.c2.addr", mem_addr, {30'h40, fofs(32'h100, 1)});
      rst = 1'b1;
      tick();
      chk("abort.ren", mem_ren, 0);
      chk("abort.rd_valid", rd_valid, 0);
      chk("abort.ready", req_ready, 1);
      chk("abort.done", done, 0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("abort.post%0d", i), {done, mem_ren, mem_wen, rd_valid}, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
